// File: rtl/crc_pkg.sv
// Shared constants and types for the 3-bit-per-clock CRC link
// (the checker here and the matching encoder).
//   DATA_W / CRC_W / POLY : payload width, CRC width, and the generator's
//                           low-order taps (x^CRC_W is implicit)
//   PAR                   : bits consumed per clock (fixed at 3)
//   CW_W / NB             : codeword width and beats per codeword
//   SH_W / CNT_W          : padded shift-register width and beat-counter width
package crc_pkg;

  localparam int DATA_W = 10;
  localparam int CRC_W  = 3;
  localparam logic [CRC_W-1:0] POLY = 3'b011;
  localparam int PAR    = 3;

  localparam int CW_W  = DATA_W + CRC_W;
  localparam int NB    = (CW_W + PAR - 1) / PAR;
  localparam int SH_W  = PAR * NB;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/crc_step3.sv
// Three direct-form LFSR steps in one combinational block, MSB first.
// Used by the checker here and by the encoder's unrolled LFSR.
//   s      : current remainder
//   b      : next three message bits, b[2] is the earliest
//   s_next : remainder after all three bits
module crc_step3
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] s,
  input  logic [2:0]       b,
  output logic [CRC_W-1:0] s_next
);

  function automatic logic [CRC_W-1:0] step1(input logic [CRC_W-1:0] s_in,
                                             input logic             bit_in);
    logic fb;
    fb = s_in[CRC_W-1] ^ bit_in;
    return {s_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  logic [CRC_W-1:0] s_v;

  always_comb begin
    s_v = s;
    for (int i = 2; i >= 0; i--) begin
      s_v = step1(s_v, b[i]);
    end
    s_next = s_v;
  end

endmodule

// File: rtl/three_parallel_crc_checker.sv
// Receive-side CRC checker. Takes a full codeword (payload followed by its
// CRC), divides it by the generator three bits per clock and reports the
// payload, the syndrome and a pass flag through a valid/ready handshake.
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   cw_in/cw_valid : codeword in (MSB first), accepted when cw_ready is high
//   cw_ready       : high only in IDLE
//   data_out       : payload of the last accepted codeword
//   syndrome       : codeword * x^CRC_W mod G, zero for a clean codeword
//   crc_ok         : syndrome == 0
//   out_valid      : result qualifier, held until out_ready
//   out_ready      : downstream accepts the result
module three_parallel_crc_checker
  import crc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CW_W-1:0]   cw_in,
  input  logic              cw_valid,
  output logic              cw_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_ok,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shift_q;
  logic [CRC_W-1:0]  s_q;
  logic [CRC_W-1:0]  s_step;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              last_beat;

  assign accept    = (state_q == IDLE) && cw_valid;
  assign last_beat = (state_q == RUN) && (cnt_q == CNT_W'(NB - 1));

  // Top three bits of the shift register feed the unrolled LFSR each beat.
  crc_step3 u_step (
    .s      (s_q),
    .b      (shift_q[SH_W-1 -: PAR]),
    .s_next (s_step)
  );

  always_comb begin
    state_d   = state_q;
    cw_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cw_ready = 1'b1;
        if (cw_valid) state_d = RUN;
      end
      RUN: begin
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      data_out <= '0;
      syndrome <= '0;
      crc_ok   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Zero-extension at the MSB end leaves the remainder unchanged.
        shift_q  <= SH_W'(cw_in);
        data_out <= cw_in[CW_W-1:CRC_W];
        s_q      <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        s_q     <= s_step;
        shift_q <= shift_q << PAR;
        cnt_q   <= cnt_q + 1'b1;
        if (last_beat) begin
          syndrome <= s_step;
          crc_ok   <= (s_step == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_three_parallel_crc_checker.sv
module tb_three_parallel_crc_checker;
  import crc_pkg::*;

  logic              clk;
  logic              reset;
  logic [CW_W-1:0]   cw_in;
  logic              cw_valid;
  logic              cw_ready;
  logic [DATA_W-1:0] data_out;
  logic [CRC_W-1:0]  syndrome;
  logic              crc_ok;
  logic              out_valid;
  logic              out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Hand-computed vectors for G = x^3 + x + 1.
  localparam logic [12:0] CW1 = 13'b1100000011_100; // clean
  localparam logic [12:0] CW2 = 13'b1011001011_000; // clean
  localparam logic [12:0] CW3 = 13'b1100000011_101; // bit 0 flipped, syndrome x^3 mod G = 011

  three_parallel_crc_checker dut (
    .clk       (clk),
    .reset     (reset),
    .cw_in     (cw_in),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .data_out  (data_out),
    .syndrome  (syndrome),
    .crc_ok    (crc_ok),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a codeword, wait for it to be accepted, then count edges until
  // out_valid. Returns the edge count after the accept edge (-1 on timeout).
  task automatic send(input logic [12:0] cw, output int lat);
    int guard;
    cw_in    = cw;
    cw_valid = 1'b1;
    guard    = 0;
    while (!cw_ready && guard < 30) begin tick(); guard++; end
    tick();                        // accept edge
    cw_valid = 1'b0;
    cw_in    = '0;
    lat      = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    if (!out_valid) lat = -1;
  endtask

  initial begin
    int lat;
    int acc_cyc, prev_acc;
    logic [12:0] vec [4];
    logic        ok_exp [4];

    reset     = 1'b0;
    cw_in     = '0;
    cw_valid  = 1'b0;
    out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_cw_ready",  32'(cw_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out",  32'(data_out),  32'd0);
    check("rst_syndrome",  32'(syndrome),  32'd0);
    check("rst_crc_ok",    32'(crc_ok),    32'd0);
    reset = 1'b1;
    tick();

    // Test 1: clean codeword; accept edge counts as edge 1, so out_valid is
    // seen after the 5th edge following it.
    out_ready = 1'b1;
    send(CW1, lat);
    check("t1_latency",  32'(lat),      32'd5);
    check("t1_syndrome", 32'(syndrome), 32'd0);
    check("t1_crc_ok",   32'(crc_ok),   32'd1);
    check("t1_data_out", 32'(data_out), 32'b1100000011);
    tick();
    check("t1_ov_drop",  32'(out_valid), 32'd0);
    check("t1_cw_ready", 32'(cw_ready),  32'd1);

    // Test 2: second clean codeword
    send(CW2, lat);
    check("t2_latency",  32'(lat),      32'd5);
    check("t2_syndrome", 32'(syndrome), 32'd0);
    check("t2_crc_ok",   32'(crc_ok),   32'd1);
    check("t2_data_out", 32'(data_out), 32'b1011001011);
    tick();

    // Test 3: single-bit error
    send(CW3, lat);
    check("t3_latency",  32'(lat),      32'd5);
    check("t3_syndrome", 32'(syndrome), 32'b011);
    check("t3_crc_ok",   32'(crc_ok),   32'd0);
    check("t3_data_out", 32'(data_out), 32'b1100000011);
    tick();

    // Test 4: backpressure with an ignored cw_valid pulse
    out_ready = 1'b0;
    send(CW2, lat);
    check("t4_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin cw_in = CW3; cw_valid = 1'b1; end
      tick();
      cw_valid = 1'b0;
      check("t4_hold_ov",  32'(out_valid), 32'd1);
      check("t4_hold_cwr", 32'(cw_ready),  32'd0);
      check("t4_hold_syn", 32'(syndrome),  32'd0);
      check("t4_hold_dat", 32'(data_out),  32'b1011001011);
    end
    out_ready = 1'b1;
    tick();
    check("t4_ov_drop",  32'(out_valid), 32'd0);
    check("t4_cw_ready", 32'(cw_ready),  32'd1);
    check("t4_crc_ok",   32'(crc_ok),    32'd1);

    // Test 5: asynchronous reset during the third RUN cycle
    cw_in    = CW3;
    cw_valid = 1'b1;
    tick();                        // accept edge
    cw_valid = 1'b0;
    tick(); tick();                // now in the third RUN cycle
    reset = 1'b0;
    #1;
    check("t5_rst_ov",  32'(out_valid), 32'd0);
    check("t5_rst_cwr", 32'(cw_ready),  32'd1);
    check("t5_rst_dat", 32'(data_out),  32'd0);
    check("t5_rst_syn", 32'(syndrome),  32'd0);
    tick();
    reset = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) lat++;
    end
    check("t5_no_output", 32'(lat),      32'd0);
    check("t5_cw_ready",  32'(cw_ready), 32'd1);
    send(CW1, lat);
    check("t5_latency",  32'(lat),      32'd5);
    check("t5_syndrome", 32'(syndrome), 32'd0);
    check("t5_crc_ok",   32'(crc_ok),   32'd1);
    check("t5_data_out", 32'(data_out), 32'b1100000011);
    tick();

    // Test 6: back-to-back with cw_valid held high
    vec[0] = CW1; ok_exp[0] = 1'b1;
    vec[1] = CW3; ok_exp[1] = 1'b0;
    vec[2] = CW1; ok_exp[2] = 1'b1;
    vec[3] = CW3; ok_exp[3] = 1'b0;
    out_ready = 1'b1;
    cw_valid  = 1'b1;
    prev_acc  = 0;
    for (int k = 0; k < 4; k++) begin
      int guard;
      cw_in = vec[k];
      guard = 0;
      while (!cw_ready && guard < 30) begin tick(); guard++; end
      tick();                      // accept edge
      acc_cyc = cyc;
      if (k > 0) check("t6_period", 32'(acc_cyc - prev_acc), 32'd7);
      prev_acc = acc_cyc;
      lat = 0;
      while (!out_valid && lat < 30) begin tick(); lat++; end
      check("t6_latency", 32'(lat),    32'd5);
      check("t6_crc_ok",  32'(crc_ok), 32'(ok_exp[k]));
    end
    cw_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
